regfile_writeback_queue: RTL and testbench

- Writer-side front end for the 32x32 register file. It accepts write-back results from two producers: the ALU path (A) and the memory/long-latency path (M).
- Results are buffered in a small in-order queue and drained one per cycle onto the register file write port (WriteReg, WriteData, RegWriteActive).
- It exports a pending-write bitmap so the hazard logic can stall readers of registers with queued writes.

---
 rtl/regfile_writeback_queue.sv | 111 +++++++++++
 tb/tb_regfile_writeback_queue.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_queue.sv
// Write-back front end for the 32x32 register file: merges ALU and memory results
// into a small in-order queue and drains one entry per cycle onto the write port.
module regfile_writeback_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      AluValid,
  input  logic [ADDR_W-1:0]         AluReg,
  input  logic [DATA_W-1:0]         AluData,
  output logic                      AluReady,
  input  logic                      MemValid,
  input  logic [ADDR_W-1:0]         MemReg,
  input  logic [DATA_W-1:0]         MemData,
  output logic                      MemReady,
  input  logic                      WbStall,
  output logic [ADDR_W-1:0]         WriteReg,
  output logic [DATA_W-1:0]         WriteData,
  output logic                      RegWriteActive,
  output logic [31:0]               PendingMask,
  output logic [$clog2(DEPTH):0]    Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] qReg  [DEPTH];
  logic [DATA_W-1:0] qData [DEPTH];

  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] memSlot;
  logic [CNT_W-1:0] freeSlots;
  logic [CNT_W-1:0] enqCount;
  logic             aluEnq;
  logic             memEnq;
  logic             doPop;

  // Readiness looks only at registered occupancy; a same-cycle pop is not credited,
  // which keeps Ready off the WbStall path.
  always_comb begin
    freeSlots = CNT_W'(DEPTH) - Count;
    AluReady  = (freeSlots >= CNT_W'(1));
    MemReady  = AluValid ? (freeSlots >= CNT_W'(2)) : (freeSlots >= CNT_W'(1));
  end

  // Writes to register 0 finish the handshake but never occupy a slot.
  always_comb begin
    aluEnq   = AluValid && AluReady && (AluReg != '0);
    memEnq   = MemValid && MemReady && (MemReg != '0);
    enqCount = CNT_W'(aluEnq) + CNT_W'(memEnq);
    memSlot  = wrPtr + PTR_W'(aluEnq);
    doPop    = (Count != '0) && !WbStall;
  end

  // NOTE: queue storage has no reset; only the rdPtr..rdPtr+Count-1 window is
  // ever read, so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (aluEnq) begin
      qReg[wrPtr]  <= AluReg;
      qData[wrPtr] <= AluData;
    end
    if (memEnq) begin
      qReg[memSlot]  <= MemReg;
      qData[memSlot] <= MemData;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      Count <= '0;
    end else begin
      wrPtr <= wrPtr + PTR_W'(enqCount);
      rdPtr <= rdPtr + PTR_W'(doPop);
      Count <= Count + enqCount - CNT_W'(doPop);
    end
  end

  // Write port registers: data holds when idle, strobe is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WriteReg       <= '0;
      WriteData      <= '0;
      RegWriteActive <= 1'b0;
    end else begin
      RegWriteActive <= doPop;
      if (doPop) begin
        WriteReg  <= qReg[rdPtr];
        WriteData <= qData[rdPtr];
      end
    end
  end

  // NOTE: combinational blocks assign a default before any conditional update,
  // so no path leaves an output unassigned and no latch is inferred.
  always_comb begin
    PendingMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < Count) begin
        PendingMask[qReg[rdPtr + PTR_W'(i)]] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench for regfile_writeback_queue: directed scenarios plus random
// traffic, all compared each cycle against a queue-based reference model.
module tb_regfile_writeback_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              AluValid = 1'b0;
  logic [ADDR_W-1:0] AluReg = '0;
  logic [DATA_W-1:0] AluData = '0;
  logic              AluReady;
  logic              MemValid = 1'b0;
  logic [ADDR_W-1:0] MemReg = '0;
  logic [DATA_W-1:0] MemData = '0;
  logic              MemReady;
  logic              WbStall = 1'b0;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              RegWriteActive;
  logic [31:0]       PendingMask;
  logic [CNT_W-1:0]  Count;

  regfile_writeback_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData), .AluReady(AluReady),
    .MemValid(MemValid), .MemReg(MemReg), .MemData(MemData), .MemReady(MemReady),
    .WbStall(WbStall),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWriteActive(RegWriteActive),
    .PendingMask(PendingMask), .Count(Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } entry_t;

  entry_t            q[$];
  logic              expActive = 1'b0;
  logic [ADDR_W-1:0] expReg = '0;
  logic [DATA_W-1:0] expData = '0;
  logic              aluAcc = 1'b0;
  logic              memAcc = 1'b0;
  int                checks = 0;
  int                errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelMask();
    logic [31:0] m = '0;
    foreach (q[i]) m[q[i].r] = 1'b1;
    return m;
  endfunction

  task automatic modelReset();
    q.delete();
    expActive = 1'b0;
    expReg    = '0;
    expData   = '0;
  endtask

  // One clock: check readiness, advance the model, then check registered outputs.
  task automatic step();
    int   freeSlots;
    logic expAluReady, expMemReady;
    entry_t e;
    #1;
    freeSlots   = DEPTH - q.size();
    expAluReady = (freeSlots >= 1);
    expMemReady = AluValid ? (freeSlots >= 2) : (freeSlots >= 1);
    check("AluReady", 32'(AluReady), 32'(expAluReady));
    check("MemReady", 32'(MemReady), 32'(expMemReady));
    aluAcc = AluValid && expAluReady;
    memAcc = MemValid && expMemReady;
    expActive = (q.size() > 0) && !WbStall;
    if (expActive) begin
      e = q.pop_front();
      expReg  = e.r;
      expData = e.d;
    end
    if (aluAcc && AluReg != 0) begin
      e.r = AluReg; e.d = AluData; q.push_back(e);
    end
    if (memAcc && MemReg != 0) begin
      e.r = MemReg; e.d = MemData; q.push_back(e);
    end
    @(posedge clk);
    #1;
    check("RegWriteActive", 32'(RegWriteActive), 32'(expActive));
    check("WriteReg", 32'(WriteReg), 32'(expReg));
    check("WriteData", WriteData, expData);
    check("Count", 32'(Count), 32'(q.size()));
    check("PendingMask", PendingMask, modelMask());
  endtask

  task automatic idle();
    AluValid = 1'b0;
    MemValid = 1'b0;
  endtask

  task automatic offerAlu(input int r, input logic [31:0] d);
    AluValid = 1'b1; AluReg = ADDR_W'(r); AluData = d;
  endtask

  task automatic offerMem(input int r, input logic [31:0] d);
    MemValid = 1'b1; MemReg = ADDR_W'(r); MemData = d;
  endtask

  initial begin
    modelReset();
    #2;
    check("reset Count", 32'(Count), 32'd0);
    check("reset PendingMask", PendingMask, 32'd0);
    check("reset RegWriteActive", 32'(RegWriteActive), 32'd0);
    check("reset WriteData", WriteData, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single ALU write through an empty queue.
    offerAlu(5, 32'h0000_0414);
    step();
    check("t1 mask after accept", PendingMask, 32'h0000_0020);
    check("t1 no strobe yet", 32'(RegWriteActive), 32'd0);
    idle();
    step();
    check("t1 strobe", 32'(RegWriteActive), 32'd1);
    check("t1 WriteReg", 32'(WriteReg), 32'd5);
    check("t1 WriteData", WriteData, 32'h0000_0414);
    check("t1 mask cleared", PendingMask, 32'd0);
    step();
    check("t1 strobe ends", 32'(RegWriteActive), 32'd0);

    // Same-cycle dual enqueue: ALU ahead of Mem.
    offerAlu(3, 32'h0010_0005);
    offerMem(7, 32'h0810_0014);
    step();
    check("t2 Count peak", 32'(Count), 32'd2);
    idle();
    step();
    check("t2 first reg", 32'(WriteReg), 32'd3);
    check("t2 first data", WriteData, 32'h0010_0005);
    step();
    check("t2 second reg", 32'(WriteReg), 32'd7);
    check("t2 second data", WriteData, 32'h0810_0014);
    step();

    // Fill under stall, contention at free=1, full with simultaneous pop.
    WbStall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      offerAlu(k, 32'h11 * k);
      step();
    end
    offerAlu(4, 32'h44);
    offerMem(9, 32'h99);
    #1;
    check("t3 AluReady free1", 32'(AluReady), 32'd1);
    check("t3 MemReady free1", 32'(MemReady), 32'd0);
    step();
    check("t3 Count full", 32'(Count), 32'd4);
    offerAlu(5, 32'h55);
    #1;
    check("t3 AluReady full", 32'(AluReady), 32'd0);
    step();
    check("t3 Count held", 32'(Count), 32'd4);
    WbStall = 1'b0;
    step();
    check("t3 pop at full Count", 32'(Count), 32'd3);
    check("t3 pop reg1", 32'(WriteReg), 32'd1);
    step();
    check("t3 enq+pop Count", 32'(Count), 32'd3);
    check("t3 pop reg2", 32'(WriteReg), 32'd2);
    AluValid = 1'b0;
    step();
    check("t3 pop reg3", 32'(WriteReg), 32'd3);
    idle();
    step();
    check("t3 pop reg4", 32'(WriteReg), 32'd4);
    step();
    check("t3 pop reg5", 32'(WriteReg), 32'd5);
    step();
    check("t3 pop reg9", 32'(WriteReg), 32'd9);
    check("t3 pop data9", WriteData, 32'h99);
    step();
    check("t3 drained", 32'(RegWriteActive), 32'd0);

    // Register 0 is accepted and dropped.
    offerAlu(0, 32'hFFFF_FFFF);
    #1;
    check("t4 AluReady reg0", 32'(AluReady), 32'd1);
    step();
    check("t4 Count reg0", 32'(Count), 32'd0);
    check("t4 mask reg0", PendingMask, 32'd0);
    idle();
    step();
    check("t4 no strobe", 32'(RegWriteActive), 32'd0);

    // Asynchronous reset with three queued entries.
    WbStall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      offerAlu(10 + k, 32'hA0 + k);
      step();
    end
    idle();
    #3;
    rst_n = 1'b0;
    #1;
    modelReset();
    check("t5 Count async", 32'(Count), 32'd0);
    check("t5 mask async", PendingMask, 32'd0);
    check("t5 WriteReg async", 32'(WriteReg), 32'd0);
    check("t5 WriteData async", WriteData, 32'd0);
    check("t5 strobe async", 32'(RegWriteActive), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    WbStall = 1'b0;
    repeat (4) step();

    // Random traffic; producers hold Reg/Data while Valid && !Ready.
    for (int n = 0; n < 3000; n++) begin
      if (!(AluValid && !aluAcc)) begin
        AluValid = ($urandom_range(0, 1) == 1);
        AluReg   = ($urandom_range(0, 9) == 0) ? '0 : ADDR_W'($urandom_range(0, 31));
        AluData  = $urandom();
      end
      if (!(MemValid && !memAcc)) begin
        MemValid = ($urandom_range(0, 1) == 1);
        MemReg   = ($urandom_range(0, 9) == 0) ? '0 : ADDR_W'($urandom_range(0, 31));
        MemData  = $urandom();
      end
      WbStall = ($urandom_range(0, 9) < 4);
      step();
      if (RegWriteActive && WriteReg == '0) check("reg0 strobe", 32'(WriteReg), 32'd1);
    end
    idle();
    WbStall = 1'b0;
    repeat (DEPTH + 2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
